// File: rtl/edge_pkg.sv
// Shared types and constants for the edge packing stage.
package edge_pkg;
  localparam int PIX_CNT_W = 15;
  localparam int PACK_W    = 8;
  localparam logic [PIX_CNT_W-1:0] EDGE_CNT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  typedef struct packed {
    logic              last;
    logic [PACK_W-1:0] data;
  } word_t;
endpackage

// File: rtl/edge_word_fifo.sv
// Synchronous first-word-fall-through FIFO of {last,data} words with a drop flag.
module edge_word_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 16
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [PACK_W:0] push_word,
  input  logic            pop,
  output logic [PACK_W:0] head,
  output logic            empty,
  output logic            full,
  output logic            drop
);
  localparam int AW = $clog2(DEPTH);

  word_t      mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= word_t'(push_word);
  end
endmodule

// File: rtl/edge_packer.sv
// Packs a 1-bit edge stream into bytes (LSB = leftmost pixel), tags frame ends,
// counts edges per frame and queues words behind a valid/ready port.
module edge_packer #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int PACK_W     = 8,
  parameter int FIFO_DEPTH = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic        edge_in,
  input  logic        edge_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [14:0] edge_count,
  output logic        frame_done,
  output logic        overflow
);
  import edge_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  if (PACK_W != edge_pkg::PACK_W) begin : g_chk_pack
    $error("PACK_W is fixed at 8");
  end
  if (IMG_W % PACK_W != 0) begin : g_chk_w
    $error("IMG_W must be a multiple of PACK_W");
  end
  if (IMG_W * IMG_H > 32768) begin : g_chk_size
    $error("IMG_W*IMG_H must not exceed 32768");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [7:0]           sr, sr_nxt, hold_q;
  logic                 accept, word_end, frame_end;
  logic                 push_vld, pop, empty, full, drop;
  logic [8:0]           push_word, head;
  state_t               state_q, state_d;
  logic [PIX_CNT_W-1:0] cnt_q, cnt_d;

  assign accept    = enb && edge_valid;
  assign word_end  = (col[2:0] == 3'd7);
  assign frame_end = (col == COL_MAX) && (row == ROW_MAX);

  always_comb begin
    sr_nxt = sr;
    sr_nxt[col[2:0]] = edge_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      sr        <= '0;
      push_vld  <= 1'b0;
      push_word <= '0;
      overflow  <= 1'b0;
    end else begin
      // The completed word is registered here and enters the FIFO one cycle later.
      push_vld <= accept && word_end;
      if (accept) begin
        sr <= sr_nxt;
        if (word_end) push_word <= {frame_end, sr_nxt};
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE always retires after one cycle so frame_done stays a single pulse even
  // with enb low; a pixel accepted in DONE already opens the next frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ACTIVE;
        cnt_d   = PIX_CNT_W'(edge_in);
      end
      ACTIVE: if (accept) begin
        if (edge_in && cnt_q != EDGE_CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
        if (accept) begin
          state_d = ACTIVE;
          cnt_d   = PIX_CNT_W'(edge_in);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign edge_count = cnt_q;

  edge_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vld),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .drop      (drop)
  );

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Keeps the last delivered byte on out_data while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset)    hold_q <= '0;
    else if (pop) hold_q <= head[7:0];
  end

  assign out_data = empty ? hold_q : head[7:0];
  assign out_last = !empty && head[8];
endmodule

// File: tb/tb_edge_packer.sv
// Randomised bench for edge_packer against a pixel-list packing model.
module tb_edge_packer;
  localparam int W = 16, H = 2, D = 16, FPIX = W * H;

  logic        clk = 1'b0, reset = 1'b1, enb = 1'b0, edge_in = 1'b0, edge_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last, frame_done, overflow;
  logic [14:0] edge_count;

  edge_packer #(.IMG_W(W), .IMG_H(H), .PACK_W(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enb(enb), .edge_in(edge_in), .edge_valid(edge_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .edge_count(edge_count), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         nchk = 0, nerr = 0;
  int         mpos = 0, mcnt = 0, fd_cnt = 0;
  logic [7:0] macc = '0;
  logic [8:0] expq[$];
  logic [8:0] gotq[$];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) gotq.push_back({out_last, out_data});
    if (!reset && frame_done) fd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: pixel k of a frame lands in bit k%8 of word k/8; the word with the
  // frame's final pixel is tagged last; the count restarts with each frame.
  task automatic model_px(input logic e);
    if (mpos == 0) mcnt = 0;
    if (e) mcnt++;
    macc[mpos % 8] = e;
    if (mpos % 8 == 7) expq.push_back({logic'(mpos == FPIX - 1), macc});
    mpos = (mpos + 1) % FPIX;
  endtask

  task automatic px(input logic e, input logic en);
    enb = en; edge_valid = 1'b1; edge_in = e;
    @(posedge clk); #1;
    if (en) model_px(e);
    edge_valid = 1'b0; enb = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; edge_valid = 1'b0; enb = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expq.delete(); mpos = 0; mcnt = 0;
  endtask

  task automatic drain(input int total);
    out_ready = 1'b1;
    for (int i = 0; i < 500 && gotq.size() < total; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (out_valid !== 1'b0)   begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nchk++; if (out_last !== 1'b0)    begin nerr++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    nchk++; if (out_data !== 8'h00)   begin nerr++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    nchk++; if (edge_count !== 15'd0) begin nerr++; $display("FAIL reset_edge_count: got %0d want 0", edge_count); end
    nchk++; if (frame_done !== 1'b0)  begin nerr++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    nchk++; if (overflow !== 1'b0)    begin nerr++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_alternating();
    int g0, f0;
    do_reset(); g0 = gotq.size(); f0 = fd_cnt; out_ready = 1'b1;
    for (int i = 0; i < FPIX; i++) px(logic'(i % 2 == 0), 1'b1);
    drain(g0 + 4);
    nchk++; if (gotq.size() - g0 !== 4) begin nerr++; $display("FAIL alt_words: got %0d want 4", gotq.size() - g0); end
    for (int i = 0; i < 4 && g0 + i < gotq.size(); i++) begin
      nchk++;
      if (gotq[g0+i] !== {logic'(i == 3), 8'h55}) begin
        nerr++; $display("FAIL alt_word%0d: got %h want %h", i, gotq[g0+i], {logic'(i == 3), 8'h55});
      end
    end
    nchk++; if (edge_count !== 15'd16) begin nerr++; $display("FAIL alt_edge_count: got %0d want 16", edge_count); end
    nchk++; if (fd_cnt - f0 !== 1) begin nerr++; $display("FAIL alt_frame_done: got %0d pulses want 1", fd_cnt - f0); end
    nchk++; if (out_valid !== 1'b0 || out_data !== 8'h55) begin
      nerr++; $display("FAIL alt_hold: got valid=%b data=%h want valid=0 data=55", out_valid, out_data);
    end
  endtask

  task automatic test_zero_then_ones();
    int g0;
    do_reset(); g0 = gotq.size(); out_ready = 1'b1;
    for (int i = 0; i < FPIX; i++) px(1'b0, 1'b1);
    drain(g0 + 4);
    nchk++; if (edge_count !== 15'd0) begin nerr++; $display("FAIL zero_edge_count: got %0d want 0", edge_count); end
    for (int i = 0; i < FPIX; i++) px(1'b1, 1'b1);
    drain(g0 + 8);
    nchk++; if (edge_count !== 15'd32) begin nerr++; $display("FAIL ones_edge_count: got %0d want 32", edge_count); end
    nchk++; if (gotq.size() - g0 !== 8) begin nerr++; $display("FAIL zo_words: got %0d want 8", gotq.size() - g0); end
    for (int i = 0; i < 8 && g0 + i < gotq.size(); i++) begin
      nchk++;
      if (gotq[g0+i] !== {logic'(i % 4 == 3), (i < 4) ? 8'h00 : 8'hFF}) begin
        nerr++; $display("FAIL zo_word%0d: got %h", i, gotq[g0+i]);
      end
    end
  endtask

  task automatic test_overflow();
    int g0;
    do_reset(); g0 = gotq.size(); out_ready = 1'b0;
    for (int i = 0; i < 8 * (D + 1); i++) px(1'($urandom), 1'b1);
    repeat (3) @(posedge clk); #1;
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    nchk++; if (gotq.size() != g0) begin nerr++; $display("FAIL ovf_early_pop: got %0d words want 0", gotq.size() - g0); end
    expq.delete(D);
    drain(g0 + D);
    for (int i = mpos; i < FPIX; i++) px(1'($urandom), 1'b1);
    drain(g0 + expq.size());
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    nchk++; if (gotq.size() - g0 !== expq.size()) begin
      nerr++; $display("FAIL ovf_words: got %0d want %0d", gotq.size() - g0, expq.size());
    end
    for (int i = 0; i < expq.size() && g0 + i < gotq.size(); i++) begin
      nchk++; if (gotq[g0+i] !== expq[i]) begin nerr++; $display("FAIL ovf_word%0d: got %h want %h", i, gotq[g0+i], expq[i]); end
    end
  endtask

  task automatic test_full_push_pop();
    int g0;
    do_reset(); g0 = gotq.size(); out_ready = 1'b0;
    for (int i = 0; i < 8 * D; i++) px(1'($urandom), 1'b1);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) px(1'($urandom), 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    drain(g0 + D + 1);
    nchk++; if (gotq.size() - g0 !== D + 1) begin nerr++; $display("FAIL fpp_words: got %0d want %0d", gotq.size() - g0, D + 1); end
    for (int i = 0; i < expq.size() && g0 + i < gotq.size(); i++) begin
      nchk++; if (gotq[g0+i] !== expq[i]) begin nerr++; $display("FAIL fpp_word%0d: got %h want %h", i, gotq[g0+i], expq[i]); end
    end
  endtask

  task automatic test_enb_toggle();
    int g0, f0;
    do_reset(); g0 = gotq.size(); f0 = fd_cnt; out_ready = 1'b1;
    for (int i = 0; i < 2 * FPIX; i++) px(1'($urandom), logic'(i % 2 == 0));
    drain(g0 + 4);
    nchk++; if (gotq.size() - g0 !== 4) begin nerr++; $display("FAIL enb_words: got %0d want 4", gotq.size() - g0); end
    for (int i = 0; i < expq.size() && g0 + i < gotq.size(); i++) begin
      nchk++; if (gotq[g0+i] !== expq[i]) begin nerr++; $display("FAIL enb_word%0d: got %h want %h", i, gotq[g0+i], expq[i]); end
    end
    nchk++; if (edge_count !== 15'(mcnt)) begin nerr++; $display("FAIL enb_edge_count: got %0d want %0d", edge_count, mcnt); end
    nchk++; if (fd_cnt - f0 !== 1) begin nerr++; $display("FAIL enb_frame_done: got %0d pulses want 1", fd_cnt - f0); end
  endtask

  task automatic test_random_backpressure();
    int g0, f0;
    do_reset(); g0 = gotq.size(); f0 = fd_cnt;
    for (int i = 0; i < 3 * FPIX; i++) begin
      out_ready = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      px(1'($urandom), 1'b1);
    end
    drain(g0 + 12);
    nchk++; if (gotq.size() - g0 !== 12) begin nerr++; $display("FAIL rnd_words: got %0d want 12", gotq.size() - g0); end
    for (int i = 0; i < expq.size() && g0 + i < gotq.size(); i++) begin
      nchk++; if (gotq[g0+i] !== expq[i]) begin nerr++; $display("FAIL rnd_word%0d: got %h want %h", i, gotq[g0+i], expq[i]); end
    end
    nchk++; if (edge_count !== 15'(mcnt)) begin nerr++; $display("FAIL rnd_edge_count: got %0d want %0d", edge_count, mcnt); end
    nchk++; if (fd_cnt - f0 !== 3) begin nerr++; $display("FAIL rnd_frame_done: got %0d pulses want 3", fd_cnt - f0); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_word();
    int g0;
    logic [7:0] pat;
    do_reset(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) px(1'b1, 1'b1);
    do_reset(); g0 = gotq.size(); out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    nchk++; if (out_valid !== 1'b0 || gotq.size() != g0) begin
      nerr++; $display("FAIL rst_partial: got valid=%b words=%0d want valid=0 words=0", out_valid, gotq.size() - g0);
    end
    pat = 8'b0000_1111;
    for (int i = 0; i < 8; i++) px(pat[i], 1'b1);
    for (int i = 8; i < FPIX; i++) px(1'($urandom), 1'b1);
    drain(g0 + 4);
    nchk++; if (gotq.size() - g0 !== 4) begin nerr++; $display("FAIL rst_words: got %0d want 4", gotq.size() - g0); end
    nchk++; if (gotq.size() > g0 && gotq[g0] !== 9'h00F) begin nerr++; $display("FAIL rst_first_word: got %h want 00f", gotq[g0]); end
    for (int i = 0; i < expq.size() && g0 + i < gotq.size(); i++) begin
      nchk++; if (gotq[g0+i] !== expq[i]) begin nerr++; $display("FAIL rst_word%0d: got %h want %h", i, gotq[g0+i], expq[i]); end
    end
    nchk++; if (edge_count !== 15'(mcnt)) begin nerr++; $display("FAIL rst_edge_count: got %0d want %0d", edge_count, mcnt); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_zero_then_ones();
    test_overflow();
    test_full_push_pop();
    test_enb_toggle();
    test_random_backpressure();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
